// File: rtl/ad9914_pport_model.sv
// ---------------------------------------------------------------------------
// ad9914_pport_model
//
// Responder that stands in for an AD9914 on the FPGA pins: the 8-bit
// parallel register port plus a simplified digital ramp generator (DRG).
// Used in simulation benches and in loopback builds with no DDS fitted.
//
// Register file: a buffer bank written through the port and an active bank
// loaded from the buffer on an io_update rising edge. The DRG only ever
// looks at the active bank:
//   word 1 bit CFR2_RAMP_BIT = enable, word 4 = lower limit, word 5 = upper
//   limit, word 6 = rising step, word 8 [15:0] = rate.
// NUM_WORDS must therefore be at least 9 and at most 64.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   master_reset        synchronous active-high reset, same effect as rst
//   p_pwd               port width select, only 0 (8-bit) is legal
//   p_wr, p_rd          active-low write / read strobes
//   p_addr, p_data_in   byte address and write data
//   p_data_out, p_data_oe  registered read data and bus-drive enable
//   io_update           buffer-to-active transfer strobe
//   dctrl, dhold, osk   DRG direction, DRG hold, output shift keying gate
//   dover               DRG sitting at the upper limit
//   ftw                 DRG accumulator (frequency tuning word)
//   rf_on               osk AND DRG enable
//   addr_err            one-cycle pulse per illegal or conflicting access
// ---------------------------------------------------------------------------
module ad9914_pport_model #(
  parameter int NUM_WORDS     = 16,
  parameter int RATE_DIV      = 24,
  parameter int CFR2_RAMP_BIT = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        master_reset,
  input  logic        p_pwd,
  input  logic        p_wr,
  input  logic        p_rd,
  input  logic [7:0]  p_addr,
  input  logic [7:0]  p_data_in,
  output logic [7:0]  p_data_out,
  output logic        p_data_oe,
  input  logic        io_update,
  input  logic        dctrl,
  input  logic        dhold,
  input  logic        osk,
  output logic        dover,
  output logic [31:0] ftw,
  output logic        rf_on,
  output logic        addr_err
);

  localparam int         WIDX       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [8:0] ADDR_LIMIT = 9'(4 * NUM_WORDS);

  typedef enum logic [1:0] {
    DRG_IDLE,   // ramp disabled, accumulator parked at the lower limit
    DRG_LOWER,  // enabled, dctrl low: return to the lower limit
    DRG_RAMP,   // enabled, dctrl high: step towards the upper limit
    DRG_LIMIT   // enabled with lower > upper: pinned at the upper limit
  } drg_mode_t;

  // Strobe history and the write-arm flag
  logic p_wr_q, p_rd_q, io_update_q, wr_armed;

  // Register banks
  logic [31:0] buf_q [NUM_WORDS];
  logic [31:0] act_q [NUM_WORDS];
  logic [31:0] buf_d [NUM_WORDS];

  // DRG state
  logic [31:0] acc_q, acc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dover_q, dover_d;
  drg_mode_t   mode;

  // Port decode
  logic            wr_fall, wr_edge, rd_fall, upd_edge;
  logic            rd_conflict, access_ok, wr_commit, err_d;
  logic [WIDX-1:0] word_idx;
  logic [32:0]     sum;
  logic [31:0]     rate_limit;

  assign word_idx = p_addr[WIDX+1:2];

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_fall     = !p_wr && p_wr_q;
    // A write only completes if its falling edge was seen since the last
    // reset; this is what aborts a write that straddles a reset.
    wr_edge     = p_wr && !p_wr_q && wr_armed;
    rd_fall     = !p_rd && p_rd_q;
    upd_edge    = io_update && !io_update_q;
    // p_rd was low in the same cycle p_wr was last low: the read wins.
    rd_conflict = !p_rd_q;
    access_ok   = ({1'b0, p_addr} < ADDR_LIMIT) && !p_pwd;
    wr_commit   = wr_edge && access_ok && !rd_conflict;
    err_d       = (wr_edge && (!access_ok || rd_conflict)) || (rd_fall && !access_ok);

    buf_d = buf_q;
    if (wr_commit) begin
      buf_d[word_idx][{p_addr[1:0], 3'b000} +: 8] = p_data_in;
    end
  end

  // DRG next-state: mode is a pure decode of the active bank and dctrl, so a
  // mode change acts on the very next edge and any partial count is dropped.
  always_comb begin
    mode       = DRG_IDLE;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dover_d    = dover_q;
    sum        = {1'b0, acc_q} + {1'b0, act_q[6]};
    rate_limit = ({16'h0000, act_q[8][15:0]} * 32'(RATE_DIV)) - 32'd1;

    if (!act_q[1][CFR2_RAMP_BIT]) mode = DRG_IDLE;
    else if (act_q[4] > act_q[5]) mode = DRG_LIMIT;
    else if (!dctrl)              mode = DRG_LOWER;
    else                          mode = DRG_RAMP;

    case (mode)
      DRG_IDLE, DRG_LOWER: begin
        acc_d   = act_q[4];
        cnt_d   = '0;
        dover_d = 1'b0;
      end
      DRG_LIMIT: begin
        acc_d   = act_q[5];
        cnt_d   = '0;
        dover_d = 1'b1;
      end
      DRG_RAMP: begin
        if (act_q[8][15:0] == 16'd0 || act_q[6] == 32'd0) begin
          // Zero rate or zero step: fixed frequency, never reaches the limit.
          cnt_d   = '0;
          dover_d = 1'b0;
        end else if (acc_q >= act_q[5]) begin
          acc_d   = act_q[5];
          cnt_d   = '0;
          dover_d = 1'b1;
        end else if (!dhold) begin
          if (cnt_q >= rate_limit) begin
            cnt_d = '0;
            // 33-bit sum so a step past 2^32 saturates instead of wrapping.
            if (sum >= {1'b0, act_q[5]}) begin
              acc_d   = act_q[5];
              dover_d = 1'b1;
            end else begin
              acc_d   = sum[31:0];
              dover_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst || master_reset) begin
      p_wr_q      <= 1'b0;
      p_rd_q      <= 1'b0;
      io_update_q <= 1'b0;
      wr_armed    <= 1'b0;
      // NOTE: the banks are plain flops and the DDS clears them on reset, so
      // they are reset here; a RAM-backed bank could not be cleared this way.
      buf_q       <= '{default: '0};
      act_q       <= '{default: '0};
      acc_q       <= '0;
      cnt_q       <= '0;
      dover_q     <= 1'b0;
      p_data_out  <= 8'h00;
      p_data_oe   <= 1'b0;
      rf_on       <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      p_wr_q      <= p_wr;
      p_rd_q      <= p_rd;
      io_update_q <= io_update;
      if (wr_fall)      wr_armed <= 1'b1;
      else if (wr_edge) wr_armed <= 1'b0;

      buf_q <= buf_d;
      // The copy takes buf_d so a write landing on the same edge is included.
      if (upd_edge) act_q <= buf_d;

      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dover_q <= dover_d;

      p_data_oe  <= !p_rd;
      p_data_out <= (!p_rd && access_ok) ? buf_q[word_idx][{p_addr[1:0], 3'b000} +: 8] : 8'h00;
      rf_on      <= osk && act_q[1][CFR2_RAMP_BIT];
      addr_err   <= err_d;
    end
  end

  assign ftw   = acc_q;
  assign dover = dover_q;

endmodule
